// File: rtl/bus_slave_mux_pkg.sv
// Shared definitions for the bus slave mux slice.
//   state_t          : FSM state encoding (IDLE/ACTIVE/RESP; 2'd3 falls back to IDLE)
//   ERR_DATA_DEFAULT : read data returned on decode error or timeout
//   SLOT_*           : well-known slot indices
//   is_onehot()      : true when exactly one bit of the (zero-extended) vector is set
package bus_slave_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;

    localparam int unsigned SLOT_UART = 0;
    localparam int unsigned SLOT_RAM  = 7;

    // Callers zero-extend their enable vector to 32 bits, so up to 32 slots.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/bus_slave_mux_timeout.sv
// Cycle counter guarding an outstanding slave request.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count at zero
//   enable     : advance the count by one
//   expired    : count has reached TIMEOUT_CYCLES-1
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bus_slave_mux.sv
// CPU-side memory handshake routed to one of NUM_SLAVES slave slots.
//   clk, reset       : clock and synchronous active-high reset
//   mem_valid        : CPU request, held with enables until mem_ready
//   enables          : one-hot slot select from the address decoder
//   mem_ready        : one-cycle response pulse to the CPU
//   mem_rdata        : response data, held until the next response
//   slv_valid        : per-slot request (at most one bit set)
//   slv_ready        : per-slot completion
//   slv_rdata        : packed slot read data, slot i at [32*i+31:32*i]
//   err_clear        : clears bus_error
//   bus_error        : sticky flag, set by decode error or timeout
//   err_count        : saturating count of error responses
module bus_slave_mux
    import bus_slave_mux_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic [NUM_SLAVES-1:0]    enables,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    slv_valid,
    input  logic [NUM_SLAVES-1:0]    slv_ready,
    input  logic [32*NUM_SLAVES-1:0] slv_rdata,
    input  logic                     err_clear,
    output logic                     bus_error,
    output logic [7:0]               err_count
);

    state_t                state, state_next;
    logic [NUM_SLAVES-1:0] sel, sel_next;
    logic [NUM_SLAVES-1:0] slv_valid_next;
    logic                  mem_ready_next;
    logic [31:0]           mem_rdata_next;
    logic [31:0]           rdata_mux;
    logic                  err_event;
    logic                  cnt_clear, cnt_enable, expired;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(expired)
    );

    // AND-OR mux: sel is one-hot whenever this is consumed, so no priority needed.
    always_comb begin
        rdata_mux = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            rdata_mux = rdata_mux | (slv_rdata[32*i +: 32] & {32{sel[i]}});
        end
    end

    always_comb begin
        state_next     = state;
        sel_next       = sel;
        slv_valid_next = '0;
        mem_ready_next = 1'b0;
        mem_rdata_next = mem_rdata;
        err_event      = 1'b0;
        cnt_clear      = 1'b0;
        cnt_enable     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    sel_next  = enables;
                    cnt_clear = 1'b1;
                    if (is_onehot(32'(enables))) begin
                        state_next     = ST_ACTIVE;
                        slv_valid_next = enables;
                    end else begin
                        state_next     = ST_RESP;
                        mem_ready_next = 1'b1;
                        mem_rdata_next = ERR_DATA;
                        err_event      = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                // A dropped request aborts silently; a ready beats an expiring timer.
                if (!mem_valid) begin
                    state_next = ST_IDLE;
                end else if (|(slv_ready & sel)) begin
                    state_next     = ST_RESP;
                    mem_ready_next = 1'b1;
                    mem_rdata_next = rdata_mux;
                end else if (expired) begin
                    state_next     = ST_RESP;
                    mem_ready_next = 1'b1;
                    mem_rdata_next = ERR_DATA;
                    err_event      = 1'b1;
                end else begin
                    slv_valid_next = sel;
                    cnt_enable     = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel       <= '0;
            slv_valid <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            bus_error <= 1'b0;
            err_count <= '0;
        end else begin
            sel       <= sel_next;
            slv_valid <= slv_valid_next;
            mem_ready <= mem_ready_next;
            mem_rdata <= mem_rdata_next;
            if (err_event) begin
                bus_error <= 1'b1;
            end else if (err_clear) begin
                bus_error <= 1'b0;
            end
            if (err_event && (err_count != '1)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_slave_mux.sv
module tb_bus_slave_mux;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_valid;
    logic [7:0]   enables;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [7:0]   slv_valid;
    logic [7:0]   slv_ready;
    logic [255:0] slv_rdata;
    logic         err_clear;
    logic         bus_error;
    logic [7:0]   err_count;

    int errors = 0;
    int checks = 0;

    bus_slave_mux #(
        .NUM_SLAVES    (8),
        .TIMEOUT_CYCLES(4),
        .ERR_DATA      (32'hdeadbeef)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .enables  (enables),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .slv_valid(slv_valid),
        .slv_ready(slv_ready),
        .slv_rdata(slv_rdata),
        .err_clear(err_clear),
        .bus_error(bus_error),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int slot, input logic [31:0] val);
        slv_rdata[32*slot +: 32] = val;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int  waited;
        logic got;
        enables   = '0;
        slv_ready = '0;
        slv_rdata = '0;
        err_clear = 1'b0;
        mem_valid = 1'b0;
        do_reset();

        // Reset state
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_slv_valid", 32'(slv_valid), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // 1: slot 3, ready in the second slv_valid cycle
        set_slot(3, 32'h12345678);
        mem_valid = 1'b1; enables = 8'h08;
        tick();
        chk("t1_slv_valid_c1", 32'(slv_valid), 32'h08);
        chk("t1_ready_c1", 32'(mem_ready), 32'd0);
        tick();
        chk("t1_slv_valid_c2", 32'(slv_valid), 32'h08);
        slv_ready = 8'h08;
        tick();
        chk("t1_mem_ready", 32'(mem_ready), 32'd1);
        chk("t1_rdata", mem_rdata, 32'h12345678);
        chk("t1_slv_valid_off", 32'(slv_valid), 32'd0);
        slv_ready = '0; mem_valid = 1'b0;
        tick();
        chk("t1_ready_pulse", 32'(mem_ready), 32'd0);
        chk("t1_rdata_hold", mem_rdata, 32'h12345678);

        // 2: decode errors, zero and multi-hot
        mem_valid = 1'b1; enables = 8'h00;
        tick();
        chk("t2_zero_ready", 32'(mem_ready), 32'd1);
        chk("t2_zero_rdata", mem_rdata, 32'hdeadbeef);
        chk("t2_zero_slv_valid", 32'(slv_valid), 32'd0);
        chk("t2_zero_bus_error", 32'(bus_error), 32'd1);
        mem_valid = 1'b0;
        tick();
        mem_valid = 1'b1; enables = 8'h05;
        tick();
        chk("t2_multi_ready", 32'(mem_ready), 32'd1);
        chk("t2_multi_slv_valid", 32'(slv_valid), 32'd0);
        chk("t2_err_count", 32'(err_count), 32'd2);
        mem_valid = 1'b0;
        tick();

        // 3: slot 7 never ready, timeout after 4 ACTIVE cycles
        do_reset();
        mem_valid = 1'b1; enables = 8'h80;
        tick();
        chk("t3_slv_valid_c1", 32'(slv_valid), 32'h80);
        tick(); tick(); tick();
        chk("t3_slv_valid_c4", 32'(slv_valid), 32'h80);
        chk("t3_no_ready_c4", 32'(mem_ready), 32'd0);
        tick();
        chk("t3_ready_c5", 32'(mem_ready), 32'd1);
        chk("t3_rdata", mem_rdata, 32'hdeadbeef);
        chk("t3_bus_error", 32'(bus_error), 32'd1);
        chk("t3_slv_valid_off", 32'(slv_valid), 32'd0);
        mem_valid = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t3_cleared", 32'(bus_error), 32'd0);
        chk("t3_count_kept", 32'(err_count), 32'd1);

        // 4: slot 1 ready on the timeout cycle; slot 2 ready ignored
        set_slot(1, 32'hcafef00d);
        set_slot(2, 32'h0badf00d);
        mem_valid = 1'b1; enables = 8'h02;
        tick();
        tick();
        slv_ready = 8'h04;
        tick();
        chk("t4_foreign_ready_ignored", 32'(mem_ready), 32'd0);
        chk("t4_slv_valid_held", 32'(slv_valid), 32'h02);
        slv_ready = '0;
        tick();
        slv_ready = 8'h02;
        tick();
        chk("t4_ready", 32'(mem_ready), 32'd1);
        chk("t4_rdata", mem_rdata, 32'hcafef00d);
        chk("t4_no_error", 32'(bus_error), 32'd0);
        chk("t4_count", 32'(err_count), 32'd1);
        slv_ready = '0; mem_valid = 1'b0;
        tick();

        // 5: abort by dropping mem_valid, then by reset
        mem_valid = 1'b1; enables = 8'h10;
        tick();
        chk("t5_slv_valid", 32'(slv_valid), 32'h10);
        mem_valid = 1'b0;
        tick();
        chk("t5_drop_slv_valid", 32'(slv_valid), 32'd0);
        chk("t5_drop_ready", 32'(mem_ready), 32'd0);
        tick();
        chk("t5_drop_ready_later", 32'(mem_ready), 32'd0);
        mem_valid = 1'b1; enables = 8'h10;
        tick();
        reset = 1'b1; mem_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("t5_rst_slv_valid", 32'(slv_valid), 32'd0);
        chk("t5_rst_ready", 32'(mem_ready), 32'd0);
        chk("t5_rst_count", 32'(err_count), 32'd0);
        tick();
        chk("t5_rst_ready_later", 32'(mem_ready), 32'd0);

        // 6: back-to-back, the RESP cycle does not accept the next request
        set_slot(0, 32'h11111111);
        set_slot(2, 32'h22222222);
        mem_valid = 1'b1; enables = 8'h01; slv_ready = 8'h01;
        tick();
        chk("t6_a_slv_valid", 32'(slv_valid), 32'h01);
        tick();
        chk("t6_a_ready", 32'(mem_ready), 32'd1);
        chk("t6_a_rdata", mem_rdata, 32'h11111111);
        enables = 8'h04; slv_ready = 8'h04;
        tick();
        chk("t6_idle_ready", 32'(mem_ready), 32'd0);
        chk("t6_idle_slv_valid", 32'(slv_valid), 32'd0);
        tick();
        chk("t6_b_slv_valid", 32'(slv_valid), 32'h04);
        tick();
        chk("t6_b_ready", 32'(mem_ready), 32'd1);
        chk("t6_b_rdata", mem_rdata, 32'h22222222);
        mem_valid = 1'b0; slv_ready = '0;
        tick();

        // 6b: 300 forced timeouts saturate err_count
        for (int i = 0; i < 300; i++) begin
            mem_valid = 1'b1; enables = 8'h40;
            got = 1'b0;
            waited = 0;
            while (!got && waited < 10) begin
                tick();
                waited++;
                got = mem_ready;
            end
            chk("t6_timeout_resp", 32'(got), 32'd1);
            mem_valid = 1'b0;
            tick();
            if (i == 253) chk("t6_count_254", 32'(err_count), 32'hfe);
        end
        chk("t6_saturated", 32'(err_count), 32'hff);
        chk("t6_sat_bus_error", 32'(bus_error), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
